// File: rtl/octa16_bus_pkg.sv
// octa16 pin bus shared types: FSM states, byte-phase codes, pin drive levels.
// Included by octa16_sync and octa16_pin_bus.
package octa16_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STRB,
    S_REL,
    S_TURN,
    S_DONE
  } state_t;

  localparam logic [1:0] PH_ADDR_HI = 2'd0;
  localparam logic [1:0] PH_ADDR_LO = 2'd1;
  localparam logic [1:0] PH_DATA_HI = 2'd2;
  localparam logic [1:0] PH_DATA_LO = 2'd3;

  localparam logic [7:0] OE_DRIVE   = 8'hFF;
  localparam logic [7:0] OE_RELEASE = 8'h00;

  function automatic logic [7:0] bus_byte(
    input logic        we,
    input logic [1:0]  ph,
    input logic [15:0] addr,
    input logic [15:0] wdata
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (1'b1)
      ph == PH_ADDR_HI: b = addr[15:8];
      ph == PH_ADDR_LO: b = addr[7:0];
      ph == PH_DATA_HI: b = we ? wdata[15:8] : 8'h00;
      ph == PH_DATA_LO: b = we ? wdata[7:0] : 8'h00;
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

  // Reads hand the data bytes to the responder, so the pins float there.
  function automatic logic [7:0] bus_oe(
    input logic       we,
    input logic [1:0] ph
  );
    return (we || !ph[1]) ? OE_DRIVE : OE_RELEASE;
  endfunction

endpackage

// File: rtl/octa16_sync.sv
// N-flop synchronizer for asynchronous single-bit inputs.
// Resets asynchronously to 0.
module octa16_sync
  import octa16_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/octa16_pin_bus.sv
// octa16 byte-bus initiator: one 16-bit word per request over 4 strobed bytes.
// Optional ack watchdog: define OCTA16_BUS_TIMEOUT_EN.
module octa16_pin_bus
  import octa16_bus_pkg::*;
#(
  parameter int ACK_SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  input  logic [7:0]  pin_din,
  output logic [7:0]  pin_dout,
  output logic [7:0]  pin_oe,
  output logic        pin_strb,
  output logic        pin_we,
  output logic [1:0]  pin_phase,
  input  logic        pin_ack
);

  state_t      state;
  logic        ack_s;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        timed_out;

  octa16_sync #(
    .N(ACK_SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (pin_ack),
    .q  (ack_s)
  );

`ifdef OCTA16_BUS_TIMEOUT_EN
  state_t      state_q;
  logic [15:0] tcnt;
  logic [15:0] elapsed;
  logic        waiting;

  // elapsed = full cycles already spent in the current state
  assign elapsed   = (state != state_q) ? 16'd0 : tcnt;
  assign waiting   = (state == S_SETUP) || (state == S_STRB) ||
                     (state == S_REL);
  assign timed_out = waiting && (elapsed >= 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tcnt     <= '0;
      resp_err <= 1'b0;
    end else begin
      state_q <= state;
      if (elapsed != 16'hFFFF) begin
        tcnt <= elapsed + 16'd1;
      end else begin
        tcnt <= elapsed;
      end
      if (timed_out) begin
        resp_err <= 1'b1;
      end else if (state == S_DONE) begin
        resp_err <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign resp_err       = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      pin_dout   <= '0;
      pin_oe     <= OE_RELEASE;
      pin_strb   <= 1'b0;
      pin_we     <= 1'b0;
      pin_phase  <= PH_ADDR_HI;
      addr       <= '0;
      wdata      <= '0;
      rdata      <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr      <= req_addr;
            wdata     <= req_wdata;
            pin_we    <= req_we;
            rdata     <= '0;
            req_ready <= 1'b0;
            pin_phase <= PH_ADDR_HI;
            pin_dout  <= req_addr[15:8];
            pin_oe    <= OE_DRIVE;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!ack_s) begin
            pin_strb <= 1'b1;
            state    <= S_STRB;
          end
        end
        S_STRB: begin
          if (ack_s) begin
            pin_strb <= 1'b0;
            if (!pin_we && pin_phase == PH_DATA_HI) begin
              rdata[15:8] <= pin_din;
            end
            if (!pin_we && pin_phase == PH_DATA_LO) begin
              rdata[7:0] <= pin_din;
            end
            state <= S_REL;
          end
        end
        S_REL: begin
          if (!ack_s) begin
            if (pin_phase == PH_DATA_LO) begin
              pin_oe     <= OE_RELEASE;
              pin_dout   <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= pin_we ? 16'h0000 : rdata;
              state      <= S_DONE;
            end else if (!pin_we && pin_phase == PH_ADDR_LO) begin
              // bus turnaround before the responder drives data
              pin_oe    <= OE_RELEASE;
              pin_dout  <= '0;
              pin_phase <= PH_DATA_HI;
              state     <= S_TURN;
            end else begin
              pin_phase <= pin_phase + 2'd1;
              pin_dout  <= bus_byte(pin_we, pin_phase + 2'd1,
                                    addr, wdata);
              pin_oe    <= bus_oe(pin_we, pin_phase + 2'd1);
              state     <= S_SETUP;
            end
          end
        end
        S_TURN: begin
          state <= S_SETUP;
        end
        S_DONE: begin
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (timed_out) begin
        pin_strb   <= 1'b0;
        pin_oe     <= OE_RELEASE;
        pin_dout   <= '0;
        resp_valid <= 1'b1;
        resp_rdata <= '0;
        state      <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_octa16_pin_bus.sv
// Scoreboard bench for octa16_pin_bus with a handshaking byte-bus responder.
// Build with OCTA16_BUS_TIMEOUT_EN to include the ack-timeout scenario.
module tb_octa16_pin_bus;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  pin_din;
  logic [7:0]  pin_dout;
  logic [7:0]  pin_oe;
  logic        pin_strb;
  logic        pin_we;
  logic [1:0]  pin_phase;
  logic        pin_ack;

  always #5 clk = ~clk;

  octa16_pin_bus #(
    .ACK_SYNC_STAGES(2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .pin_din   (pin_din),
    .pin_dout  (pin_dout),
    .pin_oe    (pin_oe),
    .pin_strb  (pin_strb),
    .pin_we    (pin_we),
    .pin_phase (pin_phase),
    .pin_ack   (pin_ack)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [1:0] ph;
    logic [7:0] dout;
    logic [7:0] oe;
    logic       we;
  } beat_t;

  exp_t        sbq[$];
  beat_t       beats[$];
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] dev_mem[logic [15:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nresp = 0;
  int ack_delay = 0;
  bit ack_never = 1'b0;
  bit unstable  = 1'b0;
  bit oe_viol   = 1'b0;
  bit prev_strb = 1'b0;
  logic [17:0] held;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a * 16'd3) ^ 16'h9E37;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: memory device on the far side of the pins.
  logic [15:0] rsp_addr;
  logic [7:0]  rsp_hi;
  logic [15:0] rv;
  always begin
    @(posedge pin_strb);
    #1;
    beats.push_back('{pin_phase, pin_dout, pin_oe, pin_we});
    case (pin_phase)
      2'd0: rsp_addr[15:8] = pin_dout;
      2'd1: rsp_addr[7:0] = pin_dout;
      2'd2: rsp_hi = pin_dout;
      default: ;
    endcase
    if (!pin_we && pin_phase[1]) begin
      rv = dev_mem.exists(rsp_addr) ? dev_mem[rsp_addr] : dflt(rsp_addr);
      pin_din = pin_phase[0] ? rv[7:0] : rv[15:8];
    end else begin
      pin_din = 8'($urandom);
    end
    if (!ack_never) begin
      repeat (ack_delay) @(negedge clk);
      pin_ack = 1'b1;
    end
    wait (!pin_strb);
    pin_ack = 1'b0;
    if (pin_we && pin_phase == 2'd3) dev_mem[rsp_addr] = {rsp_hi, pin_dout};
  end

  // Pin watcher: strobed byte must not move; reads never drive data bytes.
  always @(negedge clk) begin
    if (pin_strb) begin
      if (prev_strb && {pin_phase, pin_dout, pin_oe} !== held) unstable = 1'b1;
      held = {pin_phase, pin_dout, pin_oe};
    end
    prev_strb = pin_strb;
    if (!rst && !pin_we && pin_phase[1] && pin_oe !== 8'h00) oe_viol = 1'b1;
  end

  // Monitor: pop the scoreboard on each response.
  always @(negedge clk) begin
    exp_t  e;
    beat_t b;
    logic [7:0] xb;
    if (!rst && resp_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata %h expected none", resp_rdata);
      end else begin
        e = sbq.pop_front();
        check("rdata", 32'(resp_rdata), 32'(e.rdata));
        check("err", 32'(resp_err), 32'(e.err));
        check("oe_done", 32'(pin_oe), 32'h0);
        if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
        else if (e.lat == -2) check("tmo_wait", 32'((cyc - e.acc) > TMO), 1);
        if (!e.err) begin
          check("beat_count", beats.size(), 4);
          for (int i = 0; i < 4; i++) begin
            if (beats.size() > 0) begin
              b = beats.pop_front();
              if (i == 0) xb = e.addr[15:8];
              else if (i == 1) xb = e.addr[7:0];
              else if (!e.we) xb = 8'h00;
              else if (i == 2) xb = e.wdata[15:8];
              else xb = e.wdata[7:0];
              check($sformatf("beat%0d", i), {12'h0, b.ph, b.dout, b.oe, 3'b0, b.we},
                    {12'h0, 2'(i), xb, (e.we || i < 2) ? 8'hFF : 8'h00, 3'b0, e.we});
            end
          end
          check("strb_stable", 32'(unstable), 0);
          if (!e.we) check("read_oe", 32'(oe_viol), 0);
        end
        beats.delete();
        unstable = 1'b0;
        oe_viol  = 1'b0;
        nresp++;
      end
    end
  end

  task automatic issue(input logic we, input logic [15:0] a,
                       input logic [15:0] d, input bit hold, input bit tmo);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
      req_valid = 1'b0;
      return;
    end
    check("accept_idle", sbq.size(), 0);
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    e.rdata = (we || tmo) ? 16'h0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
    e.err   = tmo;
    e.lat   = tmo ? -2 : (ack_delay == 0 ? (we ? 29 : 30) : -1);
    e.acc   = cyc;
    if (we && !tmo) ref_mem[a] = d;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sbq.size() == 0 && req_ready) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got pending %0d expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    pin_din = '0;
    pin_ack = 1'b0;
    dev_mem[16'h00A5] = 16'hCAFE;
    ref_mem[16'h00A5] = 16'hCAFE;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 1);
    check("rst_outs", {resp_valid, resp_err, pin_strb, pin_we, pin_phase, pin_oe, pin_dout},
          32'h0);
    check("rst_rdata", 32'(resp_rdata), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 1);

    issue(1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0);
    wait_idle();
    issue(1'b0, 16'h00A5, 16'h0, 1'b0, 1'b0);
    wait_idle();
    issue(1'b0, 16'h1234, 16'h0, 1'b0, 1'b0);
    wait_idle();

    ack_delay = 10;
    issue(1'b0, 16'h00A5, 16'h0, 1'b0, 1'b0);
    wait_idle();
    issue(1'b1, 16'h0F0F, 16'h5AA5, 1'b0, 1'b0);
    wait_idle();
    ack_delay = 0;

    issue(1'b1, 16'h2222, 16'h1357, 1'b1, 1'b0);
    issue(1'b0, 16'h2222, 16'h0, 1'b0, 1'b0);
    wait_idle();

    r0 = nresp;
    issue(1'b0, 16'h00A5, 16'h0, 1'b0, 1'b0);
    n = 0;
    while (!(pin_strb && pin_phase == 2'd2) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reach_data_hi", 32'(pin_strb && pin_phase == 2'd2), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_pins", {pin_strb, pin_oe, pin_dout}, 32'h0);
    check("arst_ready", 32'(req_ready), 1);
    sbq.delete();
    repeat (2) @(negedge clk);
    beats.delete();
    unstable = 1'b0;
    oe_viol = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 1);
    check("no_resp_after_rst", nresp - r0, 0);

    for (int i = 0; i < 24; i++) begin
      ack_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      issue(1'($urandom), 16'h4000 + 16'($urandom_range(0, 7)),
            16'($urandom), 1'b0, 1'b0);
      wait_idle();
    end
    ack_delay = 0;

`ifdef OCTA16_BUS_TIMEOUT_EN
    ack_never = 1'b1;
    issue(1'b0, 16'h0777, 16'h0, 1'b0, 1'b1);
    wait_idle();
    ack_never = 1'b0;
    issue(1'b0, 16'h00A5, 16'h0, 1'b0, 1'b0);
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
